// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle SLL/SRL/SRA unit on the ALU operand-B path.
// Shifts one bit per clock using a start/busy/done handshake.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, accepted in IDLE or DONE
//   op     : 00=SLL 01=SRL 10=SRA 11=SLL
//   op_a   : value to shift
//   op_b   : shift amount source, only op_b[SHAMT_W-1:0] is used
//   busy   : high while shifting
//   done   : one-cycle result-valid pulse
//   result : shifted value, held until the next completion
module serial_shifter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [XLEN-1:0]      acc_q, acc_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic                 busy_q, done_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          acc_d   = op_a;
          cnt_d   = op_b[SHAMT_W-1:0];
          op_d    = op_e'(op);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          result_d = acc_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - SHAMT_W'(1);
          case (op_q)
            OP_SRL:  acc_d = {1'b0, acc_q[XLEN-1:1]};
            OP_SRA:  acc_d = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_d = {acc_q[XLEN-2:0], 1'b0};
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they track state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_SLL;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= (state_d == S_SHIFT);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_serial_shifter.sv
module tb_serial_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  serial_shifter #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int unsigned acc_e;
    int unsigned done_e;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc       = 0;
  int unsigned free_edge = 0;
  logic [31:0] held      = '0;
  bit          in_rst    = 1'b1;
  int          checks    = 0;
  int          errors    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned s;
    s = b % 32;
    case (o)
      2'b01:   return a >> s;
      2'b10:   return 32'($signed(a) >>> s);
      default: return a << s;
    endcase
  endfunction

  // Monitor: compares DUT outputs every cycle against the scoreboard front.
  initial begin
    bit          exp_busy, exp_done;
    logic [31:0] exp_res;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!in_rst) begin
        exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc_e) && (cyc < sb[0].done_e);
        exp_done = (sb.size() > 0) && (cyc == sb[0].done_e);
        exp_res  = exp_done ? sb[0].res : held;
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("result", result, exp_res);
        if (exp_done) begin
          held = exp_res;
          void'(sb.pop_front());
        end
      end
    end
  end

  // One input cycle; a start is accepted by the model only when the unit is free.
  task automatic step(input bit st, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    start = st;
    op    = o;
    op_a  = a;
    op_b  = b;
    if (st && cyc >= free_edge) begin
      e.res    = ref_shift(o, a, b);
      e.acc_e  = cyc + 1;
      e.done_e = cyc + 1 + (b % 32) + 1;
      free_edge = e.done_e;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 2'($urandom), $urandom, $urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (cyc <= free_edge + 2 && n < 100) begin
      idle();
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Drive a start exactly in the DONE cycle of the outstanding op.
  task automatic back_to_back(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    while (cyc + 1 < free_edge) idle();
    step(1'b1, o, a, b);
  endtask

  initial begin
    start = 1'b0;
    op    = '0;
    op_a  = '0;
    op_b  = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    in_rst = 1'b0;

    step(1'b1, 2'b00, 32'h0000_0001, 32'd4);
    drain();
    step(1'b1, 2'b10, 32'h8000_0000, 32'd31);
    drain();
    step(1'b1, 2'b01, 32'h8000_0000, 32'd31);
    drain();
    step(1'b1, 2'b01, 32'hDEAD_BEEF, 32'd0);
    drain();
    step(1'b1, 2'b00, 32'h0000_0003, 32'h0000_0025);
    drain();
    step(1'b1, 2'b11, 32'hF000_000F, 32'd8);
    drain();

    // Starts while busy are ignored, then a start in the DONE cycle chains.
    step(1'b1, 2'b01, 32'hA5A5_0F0F, 32'd6);
    repeat (3) step(1'b1, 2'b00, $urandom, $urandom);
    back_to_back(2'b10, 32'h8765_4321, 32'd3);
    back_to_back(2'b00, 32'h1234_5678, 32'd0);
    back_to_back(2'b01, 32'hFFFF_0000, 32'd16);
    drain();

    // Asynchronous reset in the middle of a 10-bit shift.
    step(1'b1, 2'b00, 32'h0000_00FF, 32'd10);
    repeat (3) idle();
    @(posedge clk);
    #3;
    in_rst = 1'b1;
    rst_n  = 1'b0;
    start  = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", result, 32'd0);
    sb.delete();
    held      = '0;
    free_edge = 0;
    @(negedge clk);
    rst_n  = 1'b1;
    in_rst = 1'b0;
    step(1'b1, 2'b10, 32'hC000_1234, 32'd5);
    drain();

    // Random traffic with mixed small and full-width shift amounts.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0)
        step(1'b1, 2'($urandom), $urandom, b);
      else
        idle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
